alu_exec_stage: RTL

- Sequencing stage directly upstream of the combinational 8-bit ALU. It accepts one decoded operation over a valid/ready handshake and registers its operands.
- It drives the ALU's a/b/opcode/cin ports, captures the ALU result and flags, and maintains the architectural flags register (Z C V N).
- It presents the result to writeback over a second valid/ready handshake.
- Provides carry-chained arithmetic (ADC/SBC-style) by feeding the stored carry flag back into the ALU cin.

---
 rtl/alu_exec_stage.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - sequencing stage that feeds a combinational 8-bit ALU and holds the Z/C/V/N flags
module alu_exec_stage #(
    parameter int DEST_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [7:0]        in_a,
    input  logic [7:0]        in_b,
    input  logic              in_use_carry,
    input  logic              in_flag_we,
    input  logic [DEST_W-1:0] in_dest,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [3:0]        alu_opcode,
    output logic              alu_cin,
    input  logic [7:0]        alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    input  logic              alu_negative,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_result,
    output logic [DEST_W-1:0] out_dest,
    output logic [3:0]        flags,
    input  logic              clear_flags,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic [7:0]          alu_a_q, alu_a_d;
    logic [7:0]          alu_b_q, alu_b_d;
    logic [3:0]          alu_opcode_q, alu_opcode_d;
    logic                alu_cin_q, alu_cin_d;
    logic                flag_we_q, flag_we_d;
    logic [DEST_W-1:0]   dest_q, dest_d;
    logic                out_valid_q, out_valid_d;
    logic [7:0]          out_result_q, out_result_d;
    logic [DEST_W-1:0]   out_dest_q, out_dest_d;
    logic [3:0]          flags_q, flags_d;

    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        busy_d       = busy_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opcode_d = alu_opcode_q;
        alu_cin_d    = alu_cin_q;
        flag_we_d    = flag_we_q;
        dest_d       = dest_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_dest_d   = out_dest_q;
        flags_d      = flags_q;

        // Invalid opcodes (>= 4'd10) still complete but never touch the flags.
        if (state_q == S_EXEC && flag_we_q && alu_opcode_q <= 4'd9) begin
            flags_d = {alu_zero, alu_carry, alu_overflow, alu_negative};
        end
        if (clear_flags) begin
            flags_d = 4'b0000;
        end

        case (state_q)
            S_IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    alu_a_d      = in_a;
                    alu_b_d      = in_b;
                    alu_opcode_d = in_op;
                    // flags_d here is the value EXEC will start with (a same-edge clear wins).
                    alu_cin_d    = in_use_carry & flags_d[2];
                    flag_we_d    = in_flag_we;
                    dest_d       = in_dest;
                    in_ready_d   = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                out_result_d = alu_result;
                out_dest_d   = dest_q;
                out_valid_d  = 1'b1;
                state_d      = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
            alu_cin_q    <= 1'b0;
            flag_we_q    <= 1'b0;
            dest_q       <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_dest_q   <= '0;
            flags_q      <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
            alu_cin_q    <= alu_cin_d;
            flag_we_q    <= flag_we_d;
            dest_q       <= dest_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_dest_q   <= out_dest_d;
            flags_q      <= flags_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_cin    = alu_cin_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_dest   = out_dest_q;
    assign flags      = flags_q;

endmodule
